apb_node_reg: RTL and testbench



---
 rtl/apb_node_pkg.sv | 16 +
 rtl/apb_addr_decode.sv | 27 ++
 rtl/apb_node_reg.sv | 163 ++++++++++++++++
 tb/tb_apb_node_reg.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_node_pkg.sv
// apb_node_pkg: shared types, constants and sizing helpers for the registered APB node
package apb_node_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_node_state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBADCAB1E;

    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: inclusive range match per port, lowest matching index wins
module apb_addr_decode
    import apb_node_pkg::*;
#(
    parameter int NB_MASTER      = 8,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int IDX_WIDTH      = idx_width(NB_MASTER)
) (
    input  logic [APB_ADDR_WIDTH-1:0]                addr,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] start_addr,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] end_addr,
    output logic                                     hit,
    output logic [IDX_WIDTH-1:0]                     idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NB_MASTER - 1; i >= 0; i--) begin
            if (addr >= start_addr[i] && addr <= end_addr[i]) begin
                hit = 1'b1;
                idx = IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/apb_node_reg.sv
// apb_node_reg: registered 1-to-N APB node with decode-miss and timeout error responses
module apb_node_reg
    import apb_node_pkg::*;
#(
    parameter int          NB_MASTER      = 8,
    parameter int          APB_ADDR_WIDTH = 32,
    parameter int          APB_DATA_WIDTH = 32,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     psel_i,
    input  logic                                     penable_i,
    input  logic                                     pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0]                paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]                pwdata_i,
    output logic [APB_DATA_WIDTH-1:0]                prdata_o,
    output logic                                     pready_o,
    output logic                                     pslverr_o,
    output logic [NB_MASTER-1:0]                     psel_o,
    output logic                                     penable_o,
    output logic                                     pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]                paddr_o,
    output logic [APB_DATA_WIDTH-1:0]                pwdata_o,
    input  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] prdata_i,
    input  logic [NB_MASTER-1:0]                     pready_i,
    input  logic [NB_MASTER-1:0]                     pslverr_i,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] end_addr_i,
    output logic                                     decerr_o,
    output logic                                     timeout_o
);

    localparam int IW = idx_width(NB_MASTER);
    localparam int CW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [APB_DATA_WIDTH-1:0] ERR_W = APB_DATA_WIDTH'(ERR_DATA);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    apb_node_state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, dec_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic dec_hit;
    logic [NB_MASTER-1:0] psel_d;
    logic penable_d, pwrite_d, pready_d, pslverr_d, decerr_d, timeout_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_d, prdata_d;

    apb_addr_decode #(
        .NB_MASTER      (NB_MASTER),
        .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
        .IDX_WIDTH      (IW)
    ) u_decode (
        .addr       (paddr_i),
        .start_addr (start_addr_i),
        .end_addr   (end_addr_i),
        .hit        (dec_hit),
        .idx        (dec_idx)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        psel_d    = psel_o;
        penable_d = penable_o;
        pwrite_d  = pwrite_o;
        paddr_d   = paddr_o;
        pwdata_d  = pwdata_o;
        prdata_d  = prdata_o;
        pslverr_d = pslverr_o;
        pready_d  = 1'b0;
        decerr_d  = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (psel_i) begin
                    paddr_d  = paddr_i;
                    pwrite_d = pwrite_i;
                    pwdata_d = pwdata_i;
                    idx_d    = dec_idx;
                    if (dec_hit) begin
                        psel_d          = '0;
                        psel_d[dec_idx] = 1'b1;
                        state_d         = SETUP;
                    end else begin
                        prdata_d  = ERR_W;
                        pslverr_d = 1'b1;
                        pready_d  = 1'b1;
                        decerr_d  = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // a ready in the abort cycle is a normal completion
                if (pready_i[idx_q]) begin
                    prdata_d  = pwrite_o ? '0 : prdata_i[idx_q];
                    pslverr_d = pslverr_i[idx_q];
                    pready_d  = 1'b1;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = RESP;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
                        psel_d    = '0;
                        penable_d = 1'b0;
                        prdata_d  = ERR_W;
                        pslverr_d = 1'b1;
                        pready_d  = 1'b1;
                        timeout_d = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            RESP: begin
                prdata_d  = '0;
                pslverr_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            psel_o    <= '0;
            penable_o <= 1'b0;
            pwrite_o  <= 1'b0;
            paddr_o   <= '0;
            pwdata_o  <= '0;
            prdata_o  <= '0;
            pready_o  <= 1'b0;
            pslverr_o <= 1'b0;
            decerr_o  <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            psel_o    <= psel_d;
            penable_o <= penable_d;
            pwrite_o  <= pwrite_d;
            paddr_o   <= paddr_d;
            pwdata_o  <= pwdata_d;
            prdata_o  <= prdata_d;
            pready_o  <= pready_d;
            pslverr_o <= pslverr_d;
            decerr_o  <= decerr_d;
            timeout_o <= timeout_d;
        end
    end

endmodule

// File: tb/tb_apb_node_reg.sv
// tb_apb_node_reg: directed scenario checks for the registered APB node
module tb_apb_node_reg;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
    logic [31:0] paddr_i = '0, pwdata_i = '0;
    logic [31:0] prdata_o, paddr_o, pwdata_o;
    logic pready_o, pslverr_o, penable_o, pwrite_o, decerr_o, timeout_o;
    logic [3:0] psel_o;
    logic [3:0][31:0] prdata_i, start_addr, end_addr;
    logic [3:0] pready_i = '0, pslverr_i = '0;
    int n_chk = 0;
    int n_fail = 0;

    apb_node_reg #(
        .NB_MASTER      (4),
        .APB_ADDR_WIDTH (32),
        .APB_DATA_WIDTH (32),
        .TIMEOUT_CYCLES (8),
        .ERR_DATA       (32'hBADCAB1E)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .psel_i       (psel_i),
        .penable_i    (penable_i),
        .pwrite_i     (pwrite_i),
        .paddr_i      (paddr_i),
        .pwdata_i     (pwdata_i),
        .prdata_o     (prdata_o),
        .pready_o     (pready_o),
        .pslverr_o    (pslverr_o),
        .psel_o       (psel_o),
        .penable_o    (penable_o),
        .pwrite_o     (pwrite_o),
        .paddr_o      (paddr_o),
        .pwdata_o     (pwdata_o),
        .prdata_i     (prdata_i),
        .pready_i     (pready_i),
        .pslverr_i    (pslverr_i),
        .start_addr_i (start_addr),
        .end_addr_i   (end_addr),
        .decerr_o     (decerr_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
        psel_i    = 1'b1;
        penable_i = 1'b0;
        pwrite_i  = wr;
        paddr_i   = addr;
        pwdata_i  = wdata;
    endtask

    task automatic end_xfer();
        psel_i    = 1'b0;
        penable_i = 1'b0;
    endtask

    task automatic set_ranges();
        for (int i = 0; i < 4; i++) begin
            start_addr[i] = 32'h1000 * (i + 1);
            end_addr[i]   = 32'h1000 * (i + 1) + 32'hFFF;
            prdata_i[i]   = '0;
        end
    endtask

    task automatic test_reset();
        #2;
        n_chk++; if ({psel_o, penable_o, pwrite_o, pready_o, pslverr_o, decerr_o, timeout_o} !== 10'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {psel_o, penable_o, pwrite_o, pready_o, pslverr_o, decerr_o, timeout_o}); end
        n_chk++; if ({paddr_o, pwdata_o, prdata_o} !== 96'b0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {paddr_o, pwdata_o, prdata_o}); end
        begin_xfer(32'h2000, 1'b0, 32'h0);
        repeat (2) tick();
        n_chk++; if (psel_o !== 4'b0000) begin n_fail++; $display("FAIL reset_hold_psel: got %b expected 0000", psel_o); end
        end_xfer();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read_hit();
        pready_i    = 4'b0010;
        prdata_i[1] = 32'hA5A5A5A5;
        begin_xfer(32'h2004, 1'b0, 32'h0);
        tick();
        n_chk++; if (psel_o !== 4'b0010) begin n_fail++; $display("FAIL hit_psel: got %b expected 0010", psel_o); end
        n_chk++; if (penable_o !== 1'b0) begin n_fail++; $display("FAIL hit_setup_penable: got %b expected 0", penable_o); end
        n_chk++; if (paddr_o !== 32'h2004) begin n_fail++; $display("FAIL hit_paddr: got %h expected 00002004", paddr_o); end
        penable_i = 1'b1;
        tick();
        n_chk++; if (penable_o !== 1'b1 || pready_o !== 1'b0) begin n_fail++; $display("FAIL hit_access: got penable=%b pready=%b expected 1 0", penable_o, pready_o); end
        tick();
        n_chk++; if (pready_o !== 1'b1 || pslverr_o !== 1'b0) begin n_fail++; $display("FAIL hit_resp: got pready=%b pslverr=%b expected 1 0", pready_o, pslverr_o); end
        n_chk++; if (prdata_o !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL hit_prdata: got %h expected a5a5a5a5", prdata_o); end
        n_chk++; if (psel_o !== 4'b0000 || penable_o !== 1'b0) begin n_fail++; $display("FAIL hit_release: got psel=%b penable=%b expected 0000 0", psel_o, penable_o); end
        end_xfer();
        tick();
        n_chk++; if (pready_o !== 1'b0 || prdata_o !== 32'h0) begin n_fail++; $display("FAIL hit_idle: got pready=%b prdata=%h expected 0 0", pready_o, prdata_o); end
        pready_i = '0;
    endtask

    task automatic test_decode_miss();
        begin_xfer(32'h9000, 1'b1, 32'h12345678);
        tick();
        n_chk++; if (pready_o !== 1'b1 || pslverr_o !== 1'b1 || decerr_o !== 1'b1) begin n_fail++; $display("FAIL miss_flags: got pready=%b pslverr=%b decerr=%b expected 1 1 1", pready_o, pslverr_o, decerr_o); end
        n_chk++; if (prdata_o !== 32'hBADCAB1E) begin n_fail++; $display("FAIL miss_prdata: got %h expected badcab1e", prdata_o); end
        n_chk++; if (psel_o !== 4'b0000) begin n_fail++; $display("FAIL miss_psel: got %b expected 0000", psel_o); end
        end_xfer();
        tick();
        n_chk++; if (decerr_o !== 1'b0 || pready_o !== 1'b0 || pslverr_o !== 1'b0) begin n_fail++; $display("FAIL miss_pulse: got decerr=%b pready=%b pslverr=%b expected 0 0 0", decerr_o, pready_o, pslverr_o); end
    endtask

    task automatic test_timeout();
        pready_i = '0;
        begin_xfer(32'h1010, 1'b0, 32'h0);
        tick();
        n_chk++; if (psel_o !== 4'b0001) begin n_fail++; $display("FAIL to_psel: got %b expected 0001", psel_o); end
        penable_i = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) begin
            tick();
            n_chk++; if (timeout_o !== 1'b0 || penable_o !== 1'b1) begin n_fail++; $display("FAIL to_wait%0d: got timeout=%b penable=%b expected 0 1", k, timeout_o, penable_o); end
        end
        tick();
        n_chk++; if (timeout_o !== 1'b1 || pready_o !== 1'b1 || pslverr_o !== 1'b1) begin n_fail++; $display("FAIL to_abort: got timeout=%b pready=%b pslverr=%b expected 1 1 1", timeout_o, pready_o, pslverr_o); end
        n_chk++; if (psel_o !== 4'b0000 || penable_o !== 1'b0) begin n_fail++; $display("FAIL to_release: got psel=%b penable=%b expected 0000 0", psel_o, penable_o); end
        n_chk++; if (prdata_o !== 32'hBADCAB1E) begin n_fail++; $display("FAIL to_prdata: got %h expected badcab1e", prdata_o); end
        end_xfer();
        tick();
        n_chk++; if (timeout_o !== 1'b0 || pready_o !== 1'b0) begin n_fail++; $display("FAIL to_pulse: got timeout=%b pready=%b expected 0 0", timeout_o, pready_o); end
    endtask

    task automatic test_timeout_ready_wins();
        pready_i = '0;
        begin_xfer(32'h1020, 1'b0, 32'h0);
        tick();
        penable_i = 1'b1;
        tick();
        repeat (7) tick();
        pready_i[0] = 1'b1;
        prdata_i[0] = 32'h12345678;
        tick();
        n_chk++; if (pready_o !== 1'b1 || timeout_o !== 1'b0 || pslverr_o !== 1'b0) begin n_fail++; $display("FAIL race_flags: got pready=%b timeout=%b pslverr=%b expected 1 0 0", pready_o, timeout_o, pslverr_o); end
        n_chk++; if (prdata_o !== 32'h12345678) begin n_fail++; $display("FAIL race_prdata: got %h expected 12345678", prdata_o); end
        pready_i = '0;
        end_xfer();
        tick();
    endtask

    task automatic test_overlap();
        start_addr[2] = 32'h1000;
        end_addr[2]   = 32'h3FFF;
        pready_i      = 4'b1111;
        prdata_i[0]   = 32'h11110000;
        prdata_i[2]   = 32'h22220000;
        begin_xfer(32'h1100, 1'b0, 32'h0);
        tick();
        n_chk++; if (psel_o !== 4'b0001) begin n_fail++; $display("FAIL ovl_psel: got %b expected 0001", psel_o); end
        penable_i = 1'b1;
        repeat (2) tick();
        n_chk++; if (pready_o !== 1'b1 || prdata_o !== 32'h11110000) begin n_fail++; $display("FAIL ovl_data: got pready=%b prdata=%h expected 1 11110000", pready_o, prdata_o); end
        end_xfer();
        tick();
        pready_i = '0;
        set_ranges();
    endtask

    task automatic test_back_to_back();
        pready_i     = '0;
        pslverr_i[3] = 1'b1;
        prdata_i[3]  = 32'hC3C3C3C3;
        begin_xfer(32'h4008, 1'b0, 32'h0);
        tick();
        n_chk++; if (psel_o !== 4'b1000) begin n_fail++; $display("FAIL ws_psel: got %b expected 1000", psel_o); end
        penable_i = 1'b1;
        repeat (4) tick();
        n_chk++; if (pready_o !== 1'b0) begin n_fail++; $display("FAIL ws_early: got pready=%b expected 0", pready_o); end
        pready_i[3] = 1'b1;
        tick();
        n_chk++; if (pready_o !== 1'b1 || pslverr_o !== 1'b1 || prdata_o !== 32'hC3C3C3C3) begin n_fail++; $display("FAIL ws_resp: got pready=%b pslverr=%b prdata=%h expected 1 1 c3c3c3c3", pready_o, pslverr_o, prdata_o); end
        pready_i     = 4'b0010;
        pslverr_i    = '0;
        prdata_i[1]  = 32'h5A5A0001;
        begin_xfer(32'h2000, 1'b1, 32'hDEADBEEF);
        tick();
        n_chk++; if (pready_o !== 1'b0 || pslverr_o !== 1'b0 || psel_o !== 4'b0000) begin n_fail++; $display("FAIL b2b_idle: got pready=%b pslverr=%b psel=%b expected 0 0 0000", pready_o, pslverr_o, psel_o); end
        penable_i = 1'b1;
        tick();
        n_chk++; if (psel_o !== 4'b0010 || pwrite_o !== 1'b1 || pwdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_setup: got psel=%b pwrite=%b pwdata=%h expected 0010 1 deadbeef", psel_o, pwrite_o, pwdata_o); end
        repeat (2) tick();
        n_chk++; if (pready_o !== 1'b1 || prdata_o !== 32'h0 || pslverr_o !== 1'b0) begin n_fail++; $display("FAIL b2b_write_resp: got pready=%b prdata=%h pslverr=%b expected 1 0 0", pready_o, prdata_o, pslverr_o); end
        end_xfer();
        tick();
        pready_i = '0;
    endtask

    task automatic test_reset_mid();
        pready_i = '0;
        begin_xfer(32'h3000, 1'b1, 32'hCAFEF00D);
        tick();
        penable_i = 1'b1;
        tick();
        n_chk++; if (psel_o !== 4'b0100 || penable_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got psel=%b penable=%b expected 0100 1", psel_o, penable_o); end
        rst_n = 1'b0;
        #1;
        n_chk++; if ({psel_o, penable_o, pwrite_o, pready_o, pslverr_o, decerr_o, timeout_o} !== 10'b0 || {paddr_o, pwdata_o, prdata_o} !== 96'b0) begin n_fail++; $display("FAIL rst_async: got psel=%b penable=%b paddr=%h pwdata=%h expected all 0", psel_o, penable_o, paddr_o, pwdata_o); end
        end_xfer();
        tick();
        rst_n = 1'b1;
        tick();
        pready_i    = 4'b0100;
        prdata_i[2] = 32'h77665544;
        begin_xfer(32'h3FFF, 1'b0, 32'h0);
        tick();
        n_chk++; if (psel_o !== 4'b0100 || pwrite_o !== 1'b0) begin n_fail++; $display("FAIL rst_fresh_setup: got psel=%b pwrite=%b expected 0100 0", psel_o, pwrite_o); end
        penable_i = 1'b1;
        repeat (2) tick();
        n_chk++; if (pready_o !== 1'b1 || prdata_o !== 32'h77665544 || pslverr_o !== 1'b0) begin n_fail++; $display("FAIL rst_fresh_resp: got pready=%b prdata=%h pslverr=%b expected 1 77665544 0", pready_o, prdata_o, pslverr_o); end
        end_xfer();
        tick();
        pready_i = '0;
    endtask

    initial begin
        set_ranges();
        test_reset();
        test_read_hit();
        test_decode_miss();
        test_timeout();
        test_timeout_ready_wins();
        test_overlap();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
